// File: rtl/q10_mul_arbiter_pkg.sv
// q10_mul_arbiter_pkg: shared Q10 constants, word type
// and the truncate-toward-zero scaling helper.
package q10_mul_arbiter_pkg;

  localparam int Q_FRAC      = 10;
  localparam int DATA_W      = 32;
  localparam int MUL_LATENCY = 3;

  typedef logic signed [DATA_W-1:0] q10_t;

  // Divide by 2^Q_FRAC rounding toward zero:
  // bias negatives before the arithmetic shift.
  function automatic q10_t q10_scale(
    input logic signed [2*DATA_W-1:0] p
  );
    logic signed [2*DATA_W-1:0] t;
    t = p;
    if (p < 0)
      t = p + ((64'sd1 <<< Q_FRAC) - 64'sd1);
    t = t >>> Q_FRAC;
    return t[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/q10_mul_arbiter_if.sv
// q10_mul_arbiter_if: requester operand/grant bus and
// shared result bus; master = requesters, slave = arbiter.
interface q10_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import q10_mul_arbiter_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]             res_valid;
  q10_t                           res_data;
  logic                           busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_data, busy
  );

endinterface

// File: rtl/q10_mul_arbiter_pipe.sv
// q10_mul_pipe: 3-stage Q10 multiply (operand, product,
// scaled result) carrying a requester tag; no stalls.
module q10_mul_pipe
  import q10_mul_arbiter_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  q10_t             in_a,
  input  q10_t             in_b,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output q10_t             out_result,
  output logic             busy
);

  logic [MUL_LATENCY-1:0] vld;
  logic [TAG_W-1:0]       tag [MUL_LATENCY];

  q10_t                       s1_a;
  q10_t                       s1_b;
  logic signed [2*DATA_W-1:0] s2_p;
  q10_t                       s3_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld  <= '0;
      s1_a <= '0;
      s1_b <= '0;
      s2_p <= '0;
      s3_r <= '0;
      for (int i = 0; i < MUL_LATENCY; i++)
        tag[i] <= '0;
    end else begin
      vld    <= {vld[MUL_LATENCY-2:0], in_valid};
      tag[0] <= in_tag;
      for (int i = 1; i < MUL_LATENCY; i++)
        tag[i] <= tag[i-1];
      s1_a <= in_a;
      s1_b <= in_b;
      s2_p <= (2*DATA_W)'(s1_a) * (2*DATA_W)'(s1_b);
      s3_r <= q10_scale(s2_p);
    end
  end

  assign out_valid  = vld[MUL_LATENCY-1];
  assign out_tag    = tag[MUL_LATENCY-1];
  assign out_result = s3_r;
  assign busy       = |vld;

endmodule

// File: rtl/q10_mul_arbiter.sv
// q10_mul_arbiter: round-robin arbiter feeding a shared
// Q10 multiply pipe; results strobed to the issuer.
module q10_mul_arbiter
  import q10_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic                 clock,
  input logic                 reset_n,
  q10_mul_arbiter_if.slave    bus
);

  localparam int TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]   last_grant;
  logic [TAG_W-1:0]   cand;
  logic [TAG_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               found;

  logic               p_valid;
  logic [TAG_W-1:0]   p_tag;

  // Search starts one past the last winner.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_grant;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = TAG_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      last_grant <= TAG_W'(NUM_REQ - 1);
    else if (found)
      last_grant <= gnt_idx;
  end

  q10_mul_pipe #(
    .TAG_W (TAG_W)
  ) u_pipe (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (found),
    .in_tag     (gnt_idx),
    .in_a       (bus.req_a[gnt_idx]),
    .in_b       (bus.req_b[gnt_idx]),
    .out_valid  (p_valid),
    .out_tag    (p_tag),
    .out_result (bus.res_data),
    .busy       (bus.busy)
  );

  assign bus.req_ready = gnt;
  assign bus.res_valid = p_valid
    ? (NUM_REQ'(1) << p_tag)
    : '0;

endmodule

// File: tb/tb_q10_mul_arbiter.sv
// tb_q10_mul_arbiter: directed and random stimulus against
// a queue-based arbitration/Q10 multiply reference model.
module tb_q10_mul_arbiter;

  localparam int NR = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b1;

  always #5 clock = ~clock;

  q10_mul_arbiter_if #(.NUM_REQ(NR)) bus ();

  q10_mul_arbiter #(.NUM_REQ(NR)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int                 due;
    int                 tag;
    logic signed [31:0] res;
  } exp_t;

  exp_t            q[$];
  int              ptr;
  int              cyc;
  int              n_tests;
  int              n_fail;
  logic [NR-1:0]   last_ready;
  logic [31:0]     obs_data;

  logic [31:0] va [4];
  logic [31:0] vb [4];
  logic [31:0] ve [4];

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A*B / 1024 with C-style truncation toward zero.
  function automatic logic signed [31:0] ref_mul(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    longint p;
    p = longint'(a) * longint'(b);
    p = p / 1024;
    return p[31:0];
  endfunction

  function automatic logic [31:0] rnd_q();
    case ($urandom_range(2))
      0: return $urandom;
      1: return 32'($urandom_range(8191)) - 32'd4096;
      default: return $urandom_range(1)
        ? 32'h7FFF_FFFF : 32'h8000_0000;
    endcase
  endfunction

  task automatic run_cycle();
    logic [NR-1:0] eg;
    int            p;
    int            idx;
    @(negedge clock);
    eg = '0;
    p  = -1;
    for (int k = 1; k <= NR; k++) begin
      idx = (ptr + k) % NR;
      if (p < 0 && bus.req_valid[idx])
        p = idx;
    end
    if (p >= 0)
      eg[p] = 1'b1;
    chk("ready", bus.req_ready, eg);
    chk("busy", bus.busy, q.size() != 0);
    if (q.size() != 0 && q[0].due == cyc) begin
      chk("res_valid", bus.res_valid, NR'(1) << q[0].tag);
      chk("res_data", bus.res_data, q[0].res);
      void'(q.pop_front());
    end else begin
      chk("res_valid", bus.res_valid, 0);
    end
    if (bus.res_valid != '0)
      obs_data = bus.res_data;
    last_ready = bus.req_ready;
    if (p >= 0) begin
      q.push_back('{due: cyc + 3, tag: p,
        res: ref_mul(bus.req_a[p], bus.req_b[p])});
      ptr = p;
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    q.delete();
    ptr = NR - 1;
    last_ready = '0;
    @(posedge clock);
    cyc++;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i] = rnd_q();
      bus.req_b[i] = rnd_q();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    ptr = NR - 1;
    obs_data = '0;
    last_ready = '0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    #2;
    do_reset();

    va[0] = 32'd1536;      vb[0] = 32'd2048;
    ve[0] = 32'd3072;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1;
    ve[1] = 32'd0;
    va[2] = -32'sd3072;    vb[2] = 32'd1536;
    ve[2] = -32'sd4608;
    va[3] = 32'h7FFF_FFFF; vb[3] = 32'h7FFF_FFFF;
    ve[3] = 32'hFFC0_0000;
    for (int v = 0; v < 4; v++) begin
      obs_data = 32'hDEAD_BEEF;
      bus.req_a[v] = va[v];
      bus.req_b[v] = vb[v];
      bus.req_valid = NR'(1) << v;
      run_cycle();
      bus.req_valid = '0;
      repeat (3) run_cycle();
      chk($sformatf("vec%0d", v), obs_data, ve[v]);
    end

    do_reset();
    rand_ops();
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      chk($sformatf("rr%0d", k), last_ready,
        NR'(1) << (k % NR));
    end
    bus.req_valid = '0;
    repeat (3) run_cycle();

    rand_ops();
    bus.req_valid = 4'b0111;
    repeat (3) run_cycle();
    do_reset();
    repeat (4) run_cycle();
    bus.req_valid = '1;
    run_cycle();
    chk("post_rst_gnt", last_ready, 4'b0001);

    bus.req_valid = 4'b1000;
    run_cycle();
    chk("gnt3", last_ready, 4'b1000);
    bus.req_valid = 4'b1100;
    run_cycle();
    chk("gnt2", last_ready, 4'b0100);
    bus.req_valid = 4'b0011;
    run_cycle();
    chk("gnt0", last_ready, 4'b0001);
    bus.req_valid = '0;
    repeat (4) run_cycle();

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i] && !last_ready[i]) begin
          if ($urandom_range(7) == 0)
            bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          bus.req_valid[i] = 1'b1;
          bus.req_a[i] = rnd_q();
          bus.req_b[i] = rnd_q();
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
      run_cycle();
    end
    bus.req_valid = '0;
    repeat (4) run_cycle();

    $display("[TB] %0d tests run, %0d failed",
      n_tests, n_fail);
    $finish;
  end

endmodule
